led_frame_sequencer: RTL and testbench
======================================

// Module: led_frame_sequencer
// PURPOSE
//  Frame-level controller for the WS2812-style bit-serial pixel driver. On start it reads NUM_LEDS
//  24-bit GRB words from a synchronous pixel RAM (addr 0..NUM_LEDS-1), hands each word to the
//  pixel driver with a load strobe, waits for that driver's done pulse, then holds the line idle
//  for the latch gap. Sits between the frame buffer / MCU-SPI front end and the pixel driver.
// PARAMETERS
//  NUM_LEDS      60    pixels per frame, >=1
//  ADDR_W        6     pixel RAM address width, 2**ADDR_W >= NUM_LEDS
//  LATCH_CYCLES  3840  clk cycles of strip reset gap after last pixel (80 us at 48 MHz), >=2
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       frame request pulse; sampled only in IDLE
//  abort       in   1       cancel current frame; go straight to latch gap
//  busy        out  1       high from the cycle after start is accepted until return to IDLE
//  frame_done  out  1       one-cycle pulse on completion (normal or aborted)
//  pix_addr    out  ADDR_W  pixel RAM read address (registered)
//  pix_rdata   in   24      pixel RAM data, valid 1 cycle after pix_addr
//  px_rgb      out  24      pixel word to driver, MSB first on the wire
//  px_load     out  1       one-cycle strobe: px_rgb valid, driver begins 24-bit transfer
//  px_done     in   1       driver pulse: current 24 bits fully shifted out
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, frame_done=0, px_load=0, pix_addr=0, px_rgb=0, latch counter=0.
//  - All outputs registered. States: IDLE, FETCH, CAPTURE, LOAD, WAIT, LATCH, FIN.
//  - IDLE: start=1 -> FETCH with pix_addr=0, idx=0. start while not IDLE is ignored (no queue).
//  - FETCH: RAM read in flight -> CAPTURE (1 cycle).
//  - CAPTURE: px_rgb <= pix_rdata (scaled if BRIGHTNESS_EN) -> LOAD.
//  - LOAD: px_load=1 for exactly this cycle -> WAIT. px_rgb held constant until px_done.
//  - WAIT: px_done=1 -> if idx==NUM_LEDS-1 go LATCH, else idx+1, pix_addr=idx+1, go FETCH.
//    px_done in any other state is ignored.
//  - Latency: start cycle N -> px_load high at cycle N+3. px_done cycle M -> next px_load at M+3.
//  - LATCH: counter counts 0..LATCH_CYCLES-1, no px_load issued; at terminal count -> FIN.
//  - FIN: frame_done=1 one cycle, busy=0 next cycle, -> IDLE. start sampled in FIN is dropped.
//  - abort=1 in FETCH/CAPTURE/LOAD/WAIT -> LATCH next cycle, counter cleared; pixel currently
//    being shifted completes on the wire inside the gap (driver not interrupted). abort in
//    LATCH/FIN/IDLE ignored. abort and px_done same cycle: abort wins.
//  - NUM_LEDS=1: single FETCH/CAPTURE/LOAD/WAIT pass then LATCH.
//  - idx is a $clog2(NUM_LEDS)-sized counter, never wraps; pix_addr = idx zero-extended to ADDR_W.
//  - Latch counter width $clog2(LATCH_CYCLES); saturates, no wrap.
//  - rst mid-frame: immediate IDLE, no frame_done, px_load low from next cycle.
// CONFIGURATION
//  LED_SEQ_BRIGHTNESS_EN defined: extra input brightness[7:0], sampled at start and held per frame.
//    Each 8-bit channel c of pix_rdata -> (c*(brightness+1))>>8 (16-bit product, truncate),
//    applied in CAPTURE; latency unchanged. brightness=255 -> data unchanged; 0 -> c>>8 = 0.
//  Not defined: no brightness port; px_rgb = pix_rdata exactly.
// TESTING
//  1 NUM_LEDS=3, RAM={FF0000,00FF00,0000FF}, start; driver model px_done 30 cyc after load ->
//    px_load x3, px_rgb in order, addr 0,1,2, frame_done exactly LATCH_CYCLES+1 cyc after 3rd px_done.
//  2 start held high for 10 cyc during frame -> exactly one frame, one frame_done pulse.
//  3 abort 2 cyc after 2nd px_load -> no 3rd px_load; LATCH entered next cyc; frame_done after gap.
//  4 rst asserted in WAIT -> next cyc busy=0, px_load=0, frame_done never pulses; new start works.
//  5 NUM_LEDS=1, spurious px_done in IDLE and LATCH -> ignored; one px_load, one frame_done.
//  6 BRIGHTNESS_EN, brightness=127, word 80FF40 -> px_rgb 407F20; brightness=255 -> 80FF40.

Source files
------------

// File: rtl/led_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_frame_sequencer_if
//   Bundles the frame sequencer's pixel-RAM read port and its handshake with
//   the bit-serial pixel driver.
//
//   Signals
//     pix_addr   [ADDR_W-1:0]  pixel RAM read address (sequencer -> RAM)
//     pix_rdata  [23:0]        pixel RAM data, one cycle after pix_addr
//     px_rgb     [23:0]        GRB word handed to the driver
//     px_load                  one-cycle strobe, px_rgb valid
//     px_done                  driver pulse, current word fully shifted out
//
//   Modports
//     master  : sequencer side
//     slave   : RAM / pixel driver side
// ---------------------------------------------------------------------------
interface led_frame_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_rdata;
    logic [23:0]       px_rgb;
    logic              px_load;
    logic              px_done;

    modport master (
        output pix_addr,
        output px_rgb,
        output px_load,
        input  pix_rdata,
        input  px_done
    );

    modport slave (
        input  pix_addr,
        input  px_rgb,
        input  px_load,
        output pix_rdata,
        output px_done
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// ---------------------------------------------------------------------------
// led_frame_sequencer
//   Frame-level controller for a WS2812-style bit-serial pixel driver. On a
//   start request it walks pixel RAM addresses 0..NUM_LEDS-1, hands each
//   24-bit GRB word to the driver with a load strobe, waits for the driver's
//   done pulse, and finally holds the line idle for the strip latch gap.
//
//   Parameters
//     NUM_LEDS      pixels per frame (>=1)
//     ADDR_W        pixel RAM address width (2**ADDR_W >= NUM_LEDS)
//     LATCH_CYCLES  clk cycles of latch gap after the last pixel (>=2)
//
//   Ports
//     clk         in   system clock
//     rst         in   synchronous, active-high reset
//     start       in   frame request, sampled only while idle
//     abort       in   cancel the current frame, go straight to the gap
//     brightness  in   [7:0] frame brightness (LED_SEQ_BRIGHTNESS_EN only)
//     busy        out  high from the cycle after start until back to idle
//     frame_done  out  one-cycle pulse at frame completion or after abort
//     bus         master modport: pixel RAM read port + driver handshake
//
//   Build option
//     LED_SEQ_BRIGHTNESS_EN : when defined, adds the brightness input; it is
//     captured with start and every colour channel is scaled by
//     (c*(brightness+1))>>8 as the word is captured. Otherwise the RAM word
//     goes to the driver unchanged.
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module led_frame_sequencer #(
    parameter int NUM_LEDS     = 60,
    parameter int ADDR_W       = 6,
    parameter int LATCH_CYCLES = 3840
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
`ifdef LED_SEQ_BRIGHTNESS_EN
    input  logic [7:0]           brightness,
`endif
    output logic                 busy,
    output logic                 frame_done,
    led_frame_sequencer_if.master bus
);

    // A one-pixel frame still needs a 1-bit index so the compare is legal.
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CNT_W = $clog2(LATCH_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_LOAD,
        S_WAIT,
        S_LATCH,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       rgb_q;
    logic [23:0]       rgb_next;
    logic              load_q;
    logic [23:0]       pix_word;

    assign bus.pix_addr = addr_q;
    assign bus.px_rgb   = rgb_q;
    assign bus.px_load  = load_q;

    // ------------------------------------------------------------------
    // Word presented to the driver: raw RAM data or brightness-scaled.
    // ------------------------------------------------------------------
`ifdef LED_SEQ_BRIGHTNESS_EN
    logic [7:0] bright_q;

    // 8x9-bit product fits 16 bits; keeping the upper byte makes 255 a
    // pass-through and 0 a blackout.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        pix_word = {scale_ch(bus.pix_rdata[23:16], bright_q),
                    scale_ch(bus.pix_rdata[15:8],  bright_q),
                    scale_ch(bus.pix_rdata[7:0],   bright_q)};
    end

    // Brightness is frozen for the whole frame at the accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '1;
        end else if (state == S_IDLE && start) begin
            bright_q <= brightness;
        end
    end
`else
    always_comb begin
        pix_word = bus.pix_rdata;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        rgb_next   = rgb_q;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    idx_next   = '0;
                end
            end

            S_FETCH: begin
                if (abort) begin
                    state_next = S_LATCH;
                    cnt_next   = '0;
                end else begin
                    state_next = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (abort) begin
                    state_next = S_LATCH;
                    cnt_next   = '0;
                end else begin
                    rgb_next   = pix_word;
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_next = S_LATCH;
                    cnt_next   = '0;
                end else begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                // abort takes priority over a coincident px_done
                if (abort) begin
                    state_next = S_LATCH;
                    cnt_next   = '0;
                end else if (bus.px_done) begin
                    if (idx == IDX_LAST) begin
                        state_next = S_LATCH;
                        cnt_next   = '0;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end

            S_LATCH: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_FIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from state_next so
    // that they line up with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            rgb_q      <= '0;
            load_q     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            addr_q     <= ADDR_W'(idx_next);
            rgb_q      <= rgb_next;
            load_q     <= (state_next == S_LOAD);
            busy       <= (state_next != S_IDLE);
            frame_done <= (state_next == S_FIN);
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_frame_sequencer
//   Bench for led_frame_sequencer. dut3 runs 3-pixel frames against a RAM
//   model and a driver model that answers each px_load with px_done 30
//   cycles later; expected words are queued at start and popped on each
//   px_load. dut1 is a one-pixel instance driven by hand.
// ---------------------------------------------------------------------------
module tb_led_frame_sequencer;

    localparam int LC        = 20;
    localparam int DRV_DELAY = 30;
    localparam int AW        = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic busy;
    logic frame_done;
    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic busy1;
    logic frame_done1;
`ifdef LED_SEQ_BRIGHTNESS_EN
    logic [7:0] brightness  = 8'hFF;
    logic [7:0] brightness1 = 8'hFF;
`endif

    led_frame_sequencer_if #(.ADDR_W(AW)) bus3 ();
    led_frame_sequencer_if #(.ADDR_W(AW)) bus1 ();

    led_frame_sequencer #(.NUM_LEDS(3), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef LED_SEQ_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus3)
    );

    led_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .abort      (abort1),
`ifdef LED_SEQ_BRIGHTNESS_EN
        .brightness (brightness1),
`endif
        .busy       (busy1),
        .frame_done (frame_done1),
        .bus        (bus1)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RAM models ----------------
    logic [23:0] ram [4];
    logic [23:0] ram1 = 24'h3CA5F0;
    initial begin
        for (int i = 0; i < 4; i++) ram[i] = 24'h0;
    end
    always @(posedge clk) bus3.pix_rdata <= ram[bus3.pix_addr];
    always @(posedge clk) bus1.pix_rdata <= (bus1.pix_addr == '0) ? ram1 : 24'hDEAD00;

    // ---------------- driver model + scoreboard for dut3 ----------------
    logic [23:0] exp_q [$];
    logic        drv_done = 1'b0;
    logic        pending  = 1'b0;
    logic        holding  = 1'b0;
    logic [23:0] held_rgb = 24'h0;
    int          done_due = 0;
    int          load_cnt = 0;
    int          fd_cnt   = 0;
    int          fd_cyc   = 0;
    int          exp_load_cyc  = -1;
    int          last_done_cyc = 0;
    assign bus3.px_done = drv_done;

    logic inj1 = 1'b0;
    int   load1_cnt = 0;
    int   load1_cyc = 0;
    int   fd1_cnt   = 0;
    int   fd1_cyc   = 0;
    assign bus1.px_done = inj1;

    always @(negedge clk) begin
        if (bus3.px_load) begin
            load_cnt++;
            check("load_cycle", cyc, exp_load_cyc);
            if (exp_q.size() == 0) begin
                check("spare_load", 32'(bus3.px_load), 32'd0);
            end else begin
                check("px_rgb", 32'(bus3.px_rgb), 32'(exp_q.pop_front()));
            end
            check("pix_addr", 32'(bus3.pix_addr), load_cnt - 1);
            held_rgb = bus3.px_rgb;
            holding  = 1'b1;
            pending  = 1'b1;
            done_due = cyc + DRV_DELAY;
        end else if (holding && busy) begin
            check("rgb_hold", 32'(bus3.px_rgb), 32'(held_rgb));
        end
        drv_done = pending && (cyc == done_due);
        if (drv_done) begin
            pending       = 1'b0;
            holding       = 1'b0;
            last_done_cyc = cyc;
            exp_load_cyc  = cyc + 3;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bus1.px_load) begin
            load1_cnt++;
            load1_cyc = cyc;
        end
        if (frame_done1) begin
            fd1_cnt++;
            fd1_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- one full dut3 frame ----------------
    task automatic run_frame(input string name,
                             input logic [0:2][23:0] ram_w,
                             input logic [0:2][23:0] exp_w,
                             input int abort_at, input int abort_delay,
                             input int hold, input int exp_loads);
        int t;
        int exp_fd;
        t = 0;
        do begin
            step();
            t++;
        end while ((busy || pending) && t < 500);
        check({name, "_idle"}, 32'(busy | pending), 32'd0);

        for (int i = 0; i < 3; i++) ram[i] = ram_w[i];
        load_cnt = 0;
        fd_cnt   = 0;
        exp_q.delete();
        for (int i = 0; i < exp_loads; i++) exp_q.push_back(exp_w[i]);

        start        = 1'b1;
        exp_load_cyc = cyc + 3;
        for (int i = 0; i < hold; i++) begin
            step();
            if (i == 0) check({name, "_busy_on"}, 32'(busy), 32'd1);
        end
        start  = 1'b0;
        exp_fd = 0;

        if (abort_at > 0) begin
            t = 0;
            while (load_cnt < abort_at && t < 2000) begin
                step();
                t++;
            end
            check({name, "_abort_wait"}, load_cnt, abort_at);
            repeat (abort_delay) step();
            abort  = 1'b1;
            exp_fd = cyc + LC + 1;
            step();
            abort = 1'b0;
        end

        t = 0;
        while (fd_cnt == 0 && t < 3000) begin
            step();
            t++;
        end
        check({name, "_fd_seen"}, fd_cnt, 1);
        if (abort_at == 0) exp_fd = last_done_cyc + LC + 1;
        check({name, "_fd_cycle"}, fd_cyc, exp_fd);
        check({name, "_busy_in_fin"}, 32'(busy), 32'd1);
        step();
        check({name, "_busy_off"}, 32'(busy), 32'd0);
        check({name, "_fd_pulse"}, 32'(frame_done), 32'd0);
        repeat (40) step();
        check({name, "_loads"}, load_cnt, exp_loads);
        check({name, "_fd_count"}, fd_cnt, 1);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [0:2][23:0] ram;
        logic [0:2][23:0] exp;
        int               abort_at;
        int               abort_delay;
        int               hold;
        int               exp_loads;
    } frame_vec_t;

    frame_vec_t vecs [5];

    initial begin
        int t;
        int s;
        int d;

        vecs[0] = '{{24'hFF0000, 24'h00FF00, 24'h0000FF}, {24'hFF0000, 24'h00FF00, 24'h0000FF}, 0, 0,  1, 3};
        vecs[1] = '{{24'h123456, 24'hABCDEF, 24'h000000}, {24'h123456, 24'hABCDEF, 24'h000000}, 0, 0, 10, 3};
        vecs[2] = '{{24'h111111, 24'h222222, 24'h333333}, {24'h111111, 24'h222222, 24'h333333}, 2, 2,  1, 2};
        vecs[3] = '{{24'hFFFFFF, 24'h800001, 24'h7E7E7E}, {24'hFFFFFF, 24'h800001, 24'h7E7E7E}, 1, DRV_DELAY, 1, 1};
        vecs[4] = '{{24'hA5A5A5, 24'h5A5A5A, 24'hC0FFEE}, {24'hA5A5A5, 24'h5A5A5A, 24'hC0FFEE}, 0, 0,  1, 3};

        // reset state
        repeat (3) step();
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_fd",      32'(frame_done),    32'd0);
        check("rst_load",    32'(bus3.px_load),  32'd0);
        check("rst_addr",    32'(bus3.pix_addr), 32'd0);
        check("rst_rgb",     32'(bus3.px_rgb),   32'd0);
        check("rst_busy1",   32'(busy1),         32'd0);
        check("rst_load1",   32'(bus1.px_load),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("v%0d", i), vecs[i].ram, vecs[i].exp,
                      vecs[i].abort_at, vecs[i].abort_delay, vecs[i].hold, vecs[i].exp_loads);
        end

        // reset while waiting for the driver
        t = 0;
        do begin
            step();
            t++;
        end while ((busy || pending) && t < 500);
        for (int i = 0; i < 3; i++) ram[i] = 24'h010203 * (i + 1);
        load_cnt = 0;
        fd_cnt   = 0;
        exp_q.delete();
        exp_q.push_back(24'h010203);
        start        = 1'b1;
        exp_load_cyc = cyc + 3;
        step();
        start = 1'b0;
        t = 0;
        while (load_cnt < 1 && t < 100) begin
            step();
            t++;
        end
        check("rstw_load", load_cnt, 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("rstw_busy", 32'(busy),          32'd0);
        check("rstw_load", 32'(bus3.px_load),  32'd0);
        check("rstw_addr", 32'(bus3.pix_addr), 32'd0);
        check("rstw_rgb",  32'(bus3.px_rgb),   32'd0);
        rst = 1'b0;
        repeat (LC + 50) step();
        check("rstw_no_fd", fd_cnt, 0);
        check("rstw_loads", load_cnt, 1);
        run_frame("after_rst", {24'hFEDCBA, 24'h0F0F0F, 24'h00FF00},
                  {24'hFEDCBA, 24'h0F0F0F, 24'h00FF00}, 0, 0, 1, 3);

`ifdef LED_SEQ_BRIGHTNESS_EN
        brightness = 8'd127;
        run_frame("bright127", {24'h80FF40, 24'hFFFFFF, 24'h010203},
                  {24'h407F20, 24'h7F7F7F, 24'h000101}, 0, 0, 1, 3);
        brightness = 8'd255;
        run_frame("bright255", {24'h80FF40, 24'hFFFFFF, 24'h010203},
                  {24'h80FF40, 24'hFFFFFF, 24'h010203}, 0, 0, 1, 3);
`endif

        // one-pixel instance with spurious px_done in IDLE and LATCH
        inj1 = 1'b1;
        step();
        inj1 = 1'b0;
        repeat (3) step();
        check("n1_idle_busy", 32'(busy1), 32'd0);
        check("n1_idle_load", load1_cnt, 0);
        load1_cnt = 0;
        fd1_cnt   = 0;
        start1    = 1'b1;
        s         = cyc;
        step();
        start1 = 1'b0;
        t = 0;
        while (load1_cnt < 1 && t < 100) begin
            step();
            t++;
        end
        check("n1_load_seen", load1_cnt, 1);
        check("n1_load_cycle", load1_cyc, s + 3);
        check("n1_rgb",  32'(bus1.px_rgb),   32'h3CA5F0);
        check("n1_addr", 32'(bus1.pix_addr), 32'd0);
        repeat (4) step();
        inj1 = 1'b1;
        d    = cyc;
        step();
        inj1 = 1'b0;
        repeat (3) step();
        inj1 = 1'b1;
        step();
        inj1 = 1'b0;
        t = 0;
        while (fd1_cnt == 0 && t < 500) begin
            step();
            t++;
        end
        check("n1_fd_cycle", fd1_cyc, d + LC + 1);
        repeat (10) step();
        check("n1_loads", load1_cnt, 1);
        check("n1_fd_count", fd1_cnt, 1);
        check("n1_busy_end", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
